// File: rtl/um_mem_ctrl_pkg.sv
// UmMemTypes: op codes, request/free-list records and FSM states shared by um_mem_ctrl and its users.
package UmMemTypes;

    localparam int UM_DATA_W = 32;

    localparam logic [2:0] OP_READ     = 3'd0;
    localparam logic [2:0] OP_WRITE    = 3'd1;
    localparam logic [2:0] OP_ALLOC    = 3'd2;
    localparam logic [2:0] OP_FREE     = 3'd3;
    localparam logic [2:0] OP_SET_ZERO = 3'd4;

    typedef enum logic [2:0] {
        MEM_READ     = OP_READ,
        MEM_WRITE    = OP_WRITE,
        MEM_ALLOC    = OP_ALLOC,
        MEM_FREE     = OP_FREE,
        MEM_SET_ZERO = OP_SET_ZERO
    } mem_op_e;

    typedef struct packed {
        mem_op_e                op;
        logic [UM_DATA_W-1:0]   address;
        logic [UM_DATA_W-1:0]   offset;
        logic [UM_DATA_W-1:0]   data;
    } mem_req_t;

    typedef struct packed {
        logic [UM_DATA_W-1:0] base;
        logic [UM_DATA_W-1:0] size;
    } free_ent_t;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, ZERO, RESP} state_e;

endpackage

// File: rtl/um_mem_ctrl_if.sv
// um_mem_if: request/response handshake between the UM execute stage (master) and um_mem_ctrl (slave).
interface um_mem_if #(parameter int DATA_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_address;
    logic [DATA_W-1:0] req_offset;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_address, req_offset, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_address, req_offset, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/um_mem_ctrl_ram.sv
// um_sp_ram: single-port synchronous RAM, one-cycle registered read (old data on collision), no reset.
module um_sp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/um_mem_ctrl.sv
// um_mem_ctrl: UM memory controller serving read/write/alloc/free/set-zero over a single-port RAM,
// with a bump allocator, a circular free list and one request in flight.
module um_mem_ctrl
    import UmMemTypes::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int HEAP_BASE  = 16,
    parameter int FREE_DEPTH = 8
) (
    input logic     clk,
    input logic     reset,
    um_mem_if.slave bus
);

    localparam int PW = $clog2(FREE_DEPTH);
    localparam logic [DATA_W:0] RAM_WORDS = (DATA_W+1)'(1) << ADDR_W;

    state_e            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] addr_q, off_q, data_q, ea_q, zcnt;
    logic [DATA_W-1:0] zero_base, next_alloc;
    logic              err_q;
    logic [ADDR_W-1:0] zaddr;
    logic [DATA_W-1:0] fl_base [FREE_DEPTH];
    logic [DATA_W-1:0] fl_size [FREE_DEPTH];
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic [DATA_W-1:0] base, ea, n;
    logic              oor, pop_ok, bump_ok, acc_err, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    // Everything decided at accept time is computed from the live request fields.
    always_comb begin
        base      = (bus.req_address == '0) ? zero_base : bus.req_address;
        ea        = base + bus.req_offset;
        oor       = |ea[DATA_W-1:ADDR_W];
        n         = (bus.req_offset == '0) ? DATA_W'(1) : bus.req_offset;
        pop_ok    = (count != '0) && (fl_size[head] >= n);
        bump_ok   = ({1'b0, next_alloc} + {1'b0, n}) <= RAM_WORDS;
        acc_err   = (bus.req_op == OP_READ || bus.req_op == OP_WRITE) ? oor :
                    (bus.req_op == OP_ALLOC) ? !(pop_ok || bump_ok) :
                    (bus.req_op == OP_FREE) ? (bus.req_address == '0 || bus.req_offset == '0) :
                    (bus.req_op != OP_SET_ZERO);
        ram_we    = (state == ZERO) ||
                    (state == RESP && !bus.resp_valid && op_q == OP_WRITE && !err_q);
        ram_addr  = (state == ZERO) ? zaddr : ea_q[ADDR_W-1:0];
        ram_wdata = (state == ZERO) ? '0 : data_q;
    end

    um_sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
            zero_base      <= '0;
            next_alloc     <= DATA_W'(HEAP_BASE);
            head           <= '0;
            tail           <= '0;
            count          <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    bus.req_ready <= 1'b0;
                    op_q          <= bus.req_op;
                    addr_q        <= bus.req_address;
                    off_q         <= bus.req_offset;
                    data_q        <= bus.req_data;
                    err_q         <= acc_err;
                    ea_q          <= ea;
                    zcnt          <= n;
                    state         <= (bus.req_op == OP_ALLOC && !acc_err) ? ZERO :
                                     (bus.req_op == OP_READ && !acc_err) ? RD_WAIT : RESP;
                    if (bus.req_op == OP_ALLOC) begin
                        ea_q  <= pop_ok ? fl_base[head] : next_alloc;
                        zaddr <= pop_ok ? fl_base[head][ADDR_W-1:0] : next_alloc[ADDR_W-1:0];
                        if (pop_ok) begin
                            head  <= head + 1'b1;
                            count <= count - 1'b1;
                        end else if (bump_ok) next_alloc <= next_alloc + n;
                    end
                end
                RD_WAIT: state <= RD_RESP;
                RD_RESP: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_data  <= ram_rdata;
                    state          <= RESP;
                end
                ZERO: begin
                    zaddr <= zaddr + 1'b1;
                    zcnt  <= zcnt - 1'b1;
                    if (zcnt == DATA_W'(1)) state <= RESP;
                end
                RESP: if (bus.resp_valid) begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end else begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= err_q;
                    bus.resp_data  <= (op_q == OP_ALLOC && !err_q) ? ea_q : '0;
                    if (op_q == OP_SET_ZERO) zero_base <= data_q;
                    // A full free list silently leaks the block.
                    if (op_q == OP_FREE && !err_q && count != (PW+1)'(FREE_DEPTH)) begin
                        fl_base[tail] <= addr_q;
                        fl_size[tail] <= off_q;
                        tail          <= tail + 1'b1;
                        count         <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_um_mem_ctrl.sv
// tb_um_mem_ctrl: directed plus randomized scoreboard bench for um_mem_ctrl against a word-array model.
module tb_um_mem_ctrl;
    import UmMemTypes::*;

    localparam int DW = 32, AW = 6, HB = 16, FD = 8, WORDS = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;

    um_mem_if #(.DATA_W(DW)) bus ();

    um_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .HEAP_BASE(HB), .FREE_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          chk;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] size;
    } blk_t;

    exp_t        exp_q[$];
    blk_t        fl[$];
    logic [31:0] mem_m [WORDS];
    bit          known [WORDS];
    logic [31:0] zb = 0;
    logic [31:0] na = HB;
    int          checks = 0, errors = 0, acc_cyc = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_data %h with nothing outstanding", bus.resp_data);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                if (e.chk) check("resp_data", bus.resp_data, e.data);
                check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_ready(string name);
        int w = 0;
        while (!bus.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready still 0 after %0d cycles, expected 1", name, w);
        end
    endtask

    task automatic issue(logic [2:0] op, logic [31:0] addr, logic [31:0] off, logic [31:0] data);
        exp_t        e;
        logic [31:0] ea, n, b;
        bit          ok;
        e  = '{data: 32'h0, err: 1'b0, chk: 1'b1, lat: 1};
        ea = ((addr == 0) ? zb : addr) + off;
        n  = (off == 0) ? 32'd1 : off;
        ok = 1'b0;
        b  = 32'h0;
        case (op)
            OP_READ:
                if (ea >= WORDS) e.err = 1'b1;
                else begin
                    e.lat  = 2;
                    e.data = mem_m[ea];
                    e.chk  = known[ea];
                end
            OP_WRITE:
                if (ea >= WORDS) e.err = 1'b1;
                else begin
                    mem_m[ea] = data;
                    known[ea] = 1'b1;
                end
            OP_ALLOC: begin
                if (fl.size() > 0 && fl[0].size >= n) begin
                    b  = fl[0].base;
                    ok = 1'b1;
                    void'(fl.pop_front());
                end else if (64'(na) + 64'(n) <= 64'(WORDS)) begin
                    b  = na;
                    na = na + n;
                    ok = 1'b1;
                end
                if (ok) begin
                    e.data = b;
                    e.lat  = int'(n) + 1;
                    for (int i = 0; i < int'(n); i++) begin
                        mem_m[int'(b) + i] = 32'h0;
                        known[int'(b) + i] = 1'b1;
                    end
                end else e.err = 1'b1;
            end
            OP_FREE:
                if (addr == 0 || off == 0) e.err = 1'b1;
                else if (fl.size() < FD) fl.push_back('{base: addr, size: off});
            OP_SET_ZERO: zb = data;
            default: e.err = 1'b1;
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        wait_ready("ready_before_req");
        bus.req_op      = op;
        bus.req_address = addr;
        bus.req_offset  = off;
        bus.req_data    = data;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        bus.req_valid = 1'b0;
        @(negedge clk);
        wait_ready("ready_after_resp");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, o;
        int          k, r;
        bus.req_valid   = 1'b0;
        bus.req_op      = 3'd0;
        bus.req_address = 32'h0;
        bus.req_offset  = 32'h0;
        bus.req_data    = 32'h0;
        foreach (known[i]) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_resp_data", bus.resp_data, 32'd0);
        check("reset_resp_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b1;
        // Allocation, clear, write/read-back and free-list reuse.
        issue(OP_ALLOC, 0, 4, 0);
        for (int i = 0; i < 4; i++) issue(OP_READ, 16, i, 0);
        issue(OP_WRITE, 16, 2, 32'hDEADBEEF);
        issue(OP_READ, 16, 2, 0);
        issue(OP_FREE, 16, 4, 0);
        issue(OP_ALLOC, 0, 3, 0);
        issue(OP_READ, 16, 2, 0);
        issue(OP_ALLOC, 0, 2, 0);
        issue(OP_WRITE, 18, 0, 32'h12345678);
        issue(OP_SET_ZERO, 0, 0, 16);
        issue(OP_READ, 0, 2, 0);
        issue(OP_READ, 32'hFFFF, 1, 0);
        issue(OP_ALLOC, 0, 100, 0);
        issue(OP_ALLOC, 0, 1, 0);
        for (int i = 0; i < 9; i++) issue(OP_FREE, 40 + i, 2, 0);
        for (int i = 0; i < 9; i++) issue(OP_ALLOC, 0, 1, 0);
        for (int i = 5; i < 8; i++) issue(3'(i), 20, 1, 32'hFFFF_FFFF);
        issue(OP_FREE, 0, 4, 0);
        issue(OP_FREE, 30, 0, 0);
        // Abort an ALLOC 10 with reset in its third cycle; no response may follow.
        @(negedge clk);
        bus.req_op      = OP_ALLOC;
        bus.req_address = 0;
        bus.req_offset  = 10;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        zb = 0;
        na = HB;
        fl.delete();
        foreach (known[i]) known[i] = 1'b0;
        repeat (12) @(negedge clk);
        issue(OP_ALLOC, 0, 4, 0);
        // Randomized mix of all ops.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            r = $urandom_range(0, 5);
            a = (r == 0) ? 32'h0 : (r == 4) ? 32'hFFFF : (r == 5) ? 32'hFFFF_FFF0 : 32'($urandom_range(1, 63));
            o = 32'($urandom_range(0, 20));
            op = (k < 3) ? OP_READ : (k < 5) ? OP_WRITE : (k < 7) ? OP_ALLOC : (k < 8) ? OP_FREE :
                 (k < 9) ? OP_SET_ZERO : 3'($urandom_range(5, 7));
            if (op == OP_ALLOC) o = 32'($urandom_range(0, 6));
            if (op == OP_FREE) begin
                a = 32'($urandom_range(0, 60));
                o = 32'($urandom_range(0, 4));
            end
            issue(op, a, o, (op == OP_SET_ZERO) ? 32'($urandom_range(0, 63)) : $urandom);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_resp: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/um_mem_ctrl.md
Name: um_mem_ctrl

Overview:
- Parametrised, handshaked successor to the UM memory system: serves read, write, alloc, free and set-zero-array requests.
- Backed by a single-port synchronous RAM.
- Alloc walks the new region one word per cycle and clears it.
- Freed blocks are recycled through a small free list.
- Sits between the UM execute stage and on-chip RAM; one request outstanding at a time.

Parameters:
- DATA_W, 32, data and address word width.
- ADDR_W, 16, RAM word-address bits; RAM depth = 2**ADDR_W.
- HEAP_BASE, 16, first word handed out by the bump allocator.
- FREE_DEPTH, 8, free-list entries (power of two).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low; state resets when reset==0 at a clk edge.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_op  in  3  0=READ, 1=WRITE, 2=ALLOC, 3=FREE, 4=SET_ZERO; 5-7 reserved.
- req_address  in  DATA_W  array base.
- req_offset  in  DATA_W  word index (READ/WRITE) or size in words (ALLOC/FREE).
- req_data  in  DATA_W  write data (WRITE) or new zero-array base (SET_ZERO).
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_W  read data or allocated base.
- resp_err  out  1  valid with resp_valid.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, zero_base=0, next_alloc=HEAP_BASE, free list empty, FSM=IDLE.
- RAM contents are not cleared by reset.
- Reset mid-operation aborts the operation with no response.
- A request is accepted when req_valid && req_ready at an edge. The request fields are captured and req_ready drops until the cycle after resp_valid.
- resp_valid is never back-pressured.
- Effective address: base = (req_address==0) ? zero_base : req_address; ea = base + req_offset, computed mod 2**DATA_W.
- Range check: ea >= 2**ADDR_W gives resp_err=1; no RAM write occurs and resp_data=0.
- FSM states: IDLE, RD_WAIT, RD_RESP, ZERO, RESP.
- READ, accepted at edge T: RAM address is driven in T+1 (RD_WAIT), RAM data is registered at T+2 (RD_RESP), and resp_valid is high in cycle T+2 → T+3. Latency is 2 cycles.
- WRITE: RAM written at edge T+1; resp_valid in the following cycle; resp_data=0.
- ALLOC of n words (n==0 treated as 1):
  - If the free list is non-empty and the head size >= n, pop the head and use its base.
  - Otherwise, if next_alloc + n <= 2**ADDR_W, use next_alloc and advance next_alloc by n.
  - Otherwise resp_err=1, resp_data=0, and no state changes.
  - On success, ZERO writes 0 to n words, one per cycle. resp_valid follows the last write with resp_data=base.
  - Total latency is n+1 cycles.
  - A popped block's leftover size is discarded.
- FREE: push {req_address, req_offset} to the free-list tail; resp_valid next cycle.
  - Full list: the entry is dropped (leak) and resp_err=0.
  - Address 0 or size 0: ignored and resp_err=1.
- SET_ZERO: zero_base <= req_data; resp_valid next cycle.
  - A READ accepted immediately afterwards uses the new base.
- Reserved op: resp_valid next cycle with resp_err=1 and no side effects.
- Free list is a circular FIFO: head/tail pointers of $clog2(FREE_DEPTH) bits plus a count of $clog2(FREE_DEPTH)+1 bits.
  - Pointers wrap to 0 after FREE_DEPTH-1.
  - Pop and push never coincide, because there is a single outstanding request.
- ALLOC may reuse a block that is still being used as zero_base; the zero-array contents are then clobbered by the clear. This is by design: software must not free the program array.

Decomposition:
- Package UmMemTypes holds:
  - mem_op_e (3-bit enum);
  - struct mem_req_t {op, address, offset, data};
  - struct free_ent_t {base, size};
  - localparam OP_* values.
- Sub-module um_sp_ram: DATA_W x 2**ADDR_W, 1-cycle registered read, write-enable port, no reset. It is instantiated once.
- The free-list FIFO and FSM stay inline.

Test Plan:
- Reset → req_ready=1, resp_valid=0. Then ALLOC size 4 → resp_data=16 after 5 cycles; words 16..19 read back 0.
- WRITE addr=16 off=2 data=0xDEADBEEF, then READ 16/2 → resp_valid exactly 2 cycles after accept with 0xDEADBEEF.
- Free reuse:
  - ALLOC 4 (base 16) then FREE 16/4.
  - ALLOC 3 → resp_data=16 and word 18 cleared.
  - Next ALLOC 2 → resp_data=20 from the bump allocator.
- SET_ZERO data=16, then READ addr=0 off=2 → value stored at word 18. READ addr=0xFFFF off=1 → resp_err=1, resp_data=0.
- With ADDR_W=6: ALLOC 100 → resp_err=1 and next_alloc unchanged. Push 9 FREEs with FREE_DEPTH=8 → 8 entries retained, 9th dropped.
- Drive reset=0 in the 3rd cycle of ALLOC 10 → no resp_valid, req_ready=1 next cycle, next ALLOC returns 16.
